bht_ctrl: RTL and testbench

Controller for the branch history table's 2-bit saturating-counter array, which has one combinational read port and one registered write port. It arbitrates the single read port between fetch-stage predictions and queued branch-resolution updates, and performs each update as a one-cycle read-modify-write. It clears the table with an init sweep after reset or flush. It sits between IF (predict), EX/MEM (resolve) and the counter array.

---
 rtl/bht_pkg.sv | 30 +++
 rtl/bht_upd_fifo.sv | 47 ++++
 rtl/bht_ctrl.sv | 145 ++++++++++++++
 tb/tb_bht_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// Shared types and helpers for the branch history table controller:
// counter encoding, init value, FSM states and the saturating update.
package bht_pkg;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t CTR_SNT  = 2'b00;
    localparam bht_ctr_t CTR_WNT  = 2'b01;
    localparam bht_ctr_t CTR_WT   = 2'b10;
    localparam bht_ctr_t CTR_ST   = 2'b11;
    localparam bht_ctr_t BHT_INIT = CTR_WNT;

    typedef enum logic {
        INIT,
        RUN
    } bht_state_e;

    // Step a 2-bit counter toward the resolved direction, saturating at the ends.
    function automatic bht_ctr_t sat_update(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_ST) res = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Update queue for resolved branches: synchronous FIFO with full/empty flags.
// Ports: clk, clr_i (sync clear), push_i/wdata_i, pop_i/rdata_o, full_o, empty_o.
module bht_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q;
    logic [AW:0]  rptr_q;
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/bht_ctrl.sv
// BHT controller: shares the counter array read port between IF predictions
// and queued resolve updates (one-cycle RMW), and sweeps the table to WNT
// after rst/flush.
// Ports: clk, rst, flush, busy; pred_valid/pred_pc -> pred_grant/pred_taken;
// upd_valid/upd_pc/upd_taken/upd_ready; arr_read/arr_load/arr_rindex/
// arr_windex/arr_datain to the array, arr_dataout back from it.
module bht_ctrl
    import bht_pkg::*;
#(
    parameter int S_INDEX    = 5,
    parameter int Q_DEPTH    = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    output logic               busy,
    input  logic               pred_valid,
    input  logic [31:0]        pred_pc,
    output logic               pred_grant,
    output logic               pred_taken,
    input  logic               upd_valid,
    input  logic [31:0]        upd_pc,
    input  logic               upd_taken,
    output logic               upd_ready,
    output logic               arr_read,
    output logic               arr_load,
    output logic [S_INDEX-1:0] arr_rindex,
    output logic [S_INDEX-1:0] arr_windex,
    output logic [1:0]         arr_datain,
    input  logic [1:0]         arr_dataout
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int QW = S_INDEX + 1;

    bht_state_e         state_q, state_d;
    logic [S_INDEX-1:0] sweep_q, sweep_d;
    logic [SW-1:0]      starve_q, starve_d;

    logic               clr;
    logic               q_push;
    logic               q_pop;
    logic               q_full;
    logic               q_empty;
    logic [QW-1:0]      q_head;
    logic [S_INDEX-1:0] head_idx;
    logic               head_taken;
    logic [S_INDEX-1:0] pred_idx;
    logic               steal;
    logic               unused_pc;

    assign clr      = rst | flush;
    assign pred_idx = pred_pc[S_INDEX+1:2];
    assign {head_idx, head_taken} = q_head;
    // A push coinciding with rst/flush is dropped along with the queue.
    assign q_push = upd_valid & upd_ready & ~clr;
    assign steal  = ~q_empty & (starve_q == SW'(STARVE_MAX));

    assign unused_pc = ^{pred_pc[31:S_INDEX+2], pred_pc[1:0],
                         upd_pc[31:S_INDEX+2], upd_pc[1:0]};

    bht_upd_fifo #(
        .DEPTH (Q_DEPTH),
        .W     (QW)
    ) u_fifo (
        .clk     (clk),
        .clr_i   (clr),
        .push_i  (q_push),
        .wdata_i ({upd_pc[S_INDEX+1:2], upd_taken}),
        .pop_i   (q_pop),
        .rdata_o (q_head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        starve_d   = starve_q;
        busy       = 1'b0;
        upd_ready  = 1'b0;
        pred_grant = 1'b0;
        pred_taken = 1'b0;
        arr_read   = 1'b0;
        arr_load   = 1'b0;
        arr_rindex = '0;
        arr_windex = '0;
        arr_datain = BHT_INIT;
        q_pop      = 1'b0;

        unique case (state_q)
            INIT: begin
                busy       = 1'b1;
                arr_load   = 1'b1;
                arr_windex = sweep_q;
                sweep_d    = sweep_q + S_INDEX'(1);
                if (sweep_q == '1) state_d = RUN;
            end
            RUN: begin
                upd_ready = ~q_full;
                if (pred_valid && !steal) begin
                    arr_rindex = pred_idx;
                    arr_read   = 1'b1;
                    pred_grant = 1'b1;
                    pred_taken = arr_dataout[1];
                end else if (!q_empty) begin
                    // Read-modify-write; the write commits at this edge so
                    // a following update to the same index sees it.
                    arr_rindex = head_idx;
                    arr_windex = head_idx;
                    arr_read   = 1'b1;
                    arr_load   = ~clr;
                    arr_datain = sat_update(arr_dataout, head_taken);
                    q_pop      = 1'b1;
                end
                if (q_empty || q_pop) begin
                    starve_d = '0;
                end else if (starve_q != SW'(STARVE_MAX)) begin
                    starve_d = starve_q + SW'(1);
                end
            end
            default: state_d = INIT;
        endcase

        if (clr) begin
            state_d  = INIT;
            sweep_d  = '0;
            starve_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INIT;
            sweep_q  <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_bht_ctrl.sv
// Self-checking bench for bht_ctrl with a behavioural counter array and
// a queue of expected array writes.
module tb_bht_ctrl;

    localparam int SI = 5;
    localparam int QD = 4;
    localparam int SM = 4;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          busy;
    logic          pred_valid = 1'b0;
    logic [31:0]   pred_pc = '0;
    logic          pred_grant;
    logic          pred_taken;
    logic          upd_valid = 1'b0;
    logic [31:0]   upd_pc = '0;
    logic          upd_taken = 1'b0;
    logic          upd_ready;
    logic          arr_read;
    logic          arr_load;
    logic [SI-1:0] arr_rindex;
    logic [SI-1:0] arr_windex;
    logic [1:0]    arr_datain;
    logic [1:0]    arr_dataout;

    int errs = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    logic [1:0]    mem [N];
    logic [1:0]    ref_tab [N];
    logic [SI+1:0] sbq [$];

    always #5 clk = ~clk;

    bht_ctrl #(
        .S_INDEX    (SI),
        .Q_DEPTH    (QD),
        .STARVE_MAX (SM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .busy        (busy),
        .pred_valid  (pred_valid),
        .pred_pc     (pred_pc),
        .pred_grant  (pred_grant),
        .pred_taken  (pred_taken),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_ready   (upd_ready),
        .arr_read    (arr_read),
        .arr_load    (arr_load),
        .arr_rindex  (arr_rindex),
        .arr_windex  (arr_windex),
        .arr_datain  (arr_datain),
        .arr_dataout (arr_dataout)
    );

    assign arr_dataout = mem[arr_rindex];

    always @(posedge clk) begin
        if (arr_load) mem[arr_windex] <= arr_datain;
    end

    function automatic logic [1:0] ref_sat(input logic [1:0] c, input logic t);
        int v;
        v = int'(c) + (t ? 1 : -1);
        if (v < 0) v = 0;
        if (v > 3) v = 3;
        return 2'(v);
    endfunction

    // Every table write outside the sweep must match the next expected write.
    always @(negedge clk) begin
        if (mon_en && !busy && arr_load) begin
            checks++;
            if (sbq.size() == 0) begin
                errs++;
                $display("FAIL write_unexpected: got idx=%0d data=%b, none expected",
                         arr_windex, arr_datain);
            end else begin
                logic [SI+1:0] e;
                e = sbq.pop_front();
                if ({arr_windex, arr_datain} !== e) begin
                    errs++;
                    $display("FAIL write_value: got idx=%0d data=%b, want idx=%0d data=%b",
                             arr_windex, arr_datain, e[SI+1:2], e[1:0]);
                end
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs; record the expected write of an accepted push.
    task automatic drive(input logic pv, input logic [31:0] ppc,
                         input logic uv, input logic [31:0] upc,
                         input logic ut, input logic fl, input logic r);
        logic [SI-1:0] idx;
        logic [1:0]    v;
        pred_valid = pv;
        pred_pc    = ppc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        flush      = fl;
        rst        = r;
        #3;
        if (uv && upd_ready && !fl && !r) begin
            idx = upc[SI+1:2];
            v = ref_sat(ref_tab[idx], ut);
            ref_tab[idx] = v;
            sbq.push_back({idx, v});
        end
    endtask

    task automatic check_sweep(input string nm);
        for (int i = 0; i < N; i++) begin
            drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({busy, arr_load, arr_windex, arr_datain, upd_ready, pred_grant, pred_taken, arr_read}
                !== {1'b1, 1'b1, 5'(i), 2'b01, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                errs++;
                $display("FAIL %s[%0d]: busy=%b load=%b widx=%0d din=%b rdy=%b grant=%b tk=%b rd=%b, want 1 1 %0d 01 0 0 0 0",
                         nm, i, busy, arr_load, arr_windex, arr_datain, upd_ready,
                         pred_grant, pred_taken, arr_read, i);
            end
            cyc();
        end
        for (int i = 0; i < N; i++) ref_tab[i] = 2'b01;
    endtask

    task automatic test_reset;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc();
        mon_en = 1'b1;
        check_sweep("reset_sweep");
        drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({busy, pred_grant, pred_taken, upd_ready} !== 4'b0101) begin
            errs++;
            $display("FAIL reset_first_pred: busy=%b grant=%b taken=%b rdy=%b, want 0 1 0 1",
                     busy, pred_grant, pred_taken, upd_ready);
        end
        cyc();
    endtask

    task automatic test_training;
        drive(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
        checks++;
        if (upd_ready !== 1'b1) begin
            errs++;
            $display("FAIL train_ready: got %b want 1", upd_ready);
        end
        cyc();
        drive(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({arr_load, arr_windex} !== {1'b1, 5'd16}) begin
            errs++;
            $display("FAIL train_pop_n1: load=%b widx=%0d want 1 16", arr_load, arr_windex);
        end
        cyc();
        drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({pred_grant, pred_taken} !== 2'b11) begin
            errs++;
            $display("FAIL train_pred_n2: grant=%b taken=%b want 1 1", pred_grant, pred_taken);
        end
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        checks++;
        if (mem[16] !== 2'b11) begin
            errs++;
            $display("FAIL train_sat_high: entry16=%b want 11", mem[16]);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        checks++;
        if (mem[16] !== 2'b00) begin
            errs++;
            $display("FAIL train_sat_low: entry16=%b want 00", mem[16]);
        end
        drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({pred_grant, pred_taken} !== 2'b10) begin
            errs++;
            $display("FAIL train_pred_nt: grant=%b taken=%b want 1 0", pred_grant, pred_taken);
        end
        cyc();
    endtask

    task automatic test_arbitration;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h104, i == 0, 32'h100, 1'b1, 1'b0, 1'b0);
            checks++;
            if ({arr_load, pred_grant} !== 2'b01) begin
                errs++;
                $display("FAIL arb_defer[%0d]: load=%b grant=%b want 0 1", i, arr_load, pred_grant);
            end
            cyc();
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({arr_load, arr_windex} !== {1'b1, 5'd0}) begin
            errs++;
            $display("FAIL arb_idle_rmw: load=%b widx=%0d want 1 0", arr_load, arr_windex);
        end
        cyc();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (arr_load !== 1'b0) begin
            errs++;
            $display("FAIL arb_after: load=%b want 0", arr_load);
        end
        cyc();
    endtask

    task automatic test_starvation;
        logic st;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100, 1'b1, 32'h88, i[0], 1'b0, 1'b0);
            checks++;
            if ({upd_ready, pred_grant} !== 2'b11) begin
                errs++;
                $display("FAIL starve_fill[%0d]: rdy=%b grant=%b want 1 1", i, upd_ready, pred_grant);
            end
            cyc();
        end
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'h100, k == 0, 32'h88, 1'b1, 1'b0, 1'b0);
            st = (k == 1) || (k == 6) || (k == 11) || (k == 16);
            if (k == 0) begin
                checks++;
                if (upd_ready !== 1'b0) begin
                    errs++;
                    $display("FAIL starve_full: rdy=%b want 0", upd_ready);
                end
            end
            checks++;
            if ({pred_grant, pred_taken, arr_load} !== {!st, !st, st}) begin
                errs++;
                $display("FAIL starve_cyc[%0d]: grant=%b taken=%b load=%b want %b %b %b",
                         k, pred_grant, pred_taken, arr_load, !st, !st, st);
            end
            cyc();
        end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
            cyc();
        end
        sbq.delete();
        drive(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
        checks++;
        if (arr_load !== 1'b0) begin
            errs++;
            $display("FAIL flush_suppress: load=%b want 0", arr_load);
        end
        cyc();
        check_sweep("flush_sweep");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({busy, upd_ready, arr_load} !== 3'b010) begin
                errs++;
                $display("FAIL flush_idle[%0d]: busy=%b rdy=%b load=%b want 0 1 0",
                         i, busy, upd_ready, arr_load);
            end
            cyc();
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (mem[i] !== 2'b01) begin
                errs++;
                $display("FAIL flush_entry[%0d]: got %b want 01", i, mem[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({busy, arr_windex} !== {1'b1, 5'd10}) begin
            errs++;
            $display("FAIL mid_rst_idx: busy=%b widx=%0d want 1 10", busy, arr_windex);
        end
        cyc();
        check_sweep("mid_rst_sweep");
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({busy, arr_load} !== 2'b00) begin
            errs++;
            $display("FAIL mid_rst_done: busy=%b load=%b want 0 0", busy, arr_load);
        end
        cyc();
    endtask

    initial begin
        for (int i = 0; i < N; i++) ref_tab[i] = 2'b01;
        test_reset();
        test_training();
        test_arbitration();
        test_starvation();
        test_flush();
        test_reset_mid();
        checks++;
        if (sbq.size() != 0) begin
            errs++;
            $display("FAIL pending_writes: got %0d outstanding want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
